// File: rtl/quad_pkg.sv
// Shared phase constants and Gray-code step classification for the quadrature decoder.
package quad_pkg;

    localparam logic [1:0] PH_00 = 2'b00;
    localparam logic [1:0] PH_10 = 2'b10;
    localparam logic [1:0] PH_11 = 2'b11;
    localparam logic [1:0] PH_01 = 2'b01;

    typedef enum logic [1:0] {
        CLS_NONE    = 2'd0,
        CLS_UP      = 2'd1,
        CLS_DOWN    = 2'd2,
        CLS_ILLEGAL = 2'd3
    } cls_e;

    // Phases are {a,b}; channel A leading B is the up (horario) direction.
    function automatic cls_e classify(input logic [1:0] prev, input logic [1:0] next);
        cls_e cls;
        case ({prev, next})
            {PH_00, PH_10}, {PH_10, PH_11}, {PH_11, PH_01}, {PH_01, PH_00}: cls = CLS_UP;
            {PH_00, PH_01}, {PH_01, PH_11}, {PH_11, PH_10}, {PH_10, PH_00}: cls = CLS_DOWN;
            default: cls = (prev == next) ? CLS_NONE : CLS_ILLEGAL;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/quad_sync_filter.sv
// Synchronises the asynchronous {a,b} pair and accepts a value only after it has
// been stable for FILTER_LEN consecutive synchronised samples.
module quad_sync_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] din,
    output logic [1:0] value,
    output logic       accept
);

    localparam int RW = $clog2(FILTER_LEN + 1);
    localparam logic [RW-1:0] RUN_MAX = RW'(FILTER_LEN);

    logic [SYNC_STAGES-1:0][1:0] sync_r;
    logic [1:0]                  last_r;
    logic [RW-1:0]               run_r;
    logic [RW-1:0]               run_s;
    logic [1:0]                  samp_s;
    logic                        same_s;

    assign samp_s = sync_r[SYNC_STAGES-1];
    assign same_s = (samp_s == last_r);

    // Synchroniser chain, previous-sample register and run-length counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= '0;
            last_r <= 2'b00;
            run_r  <= '0;
        end else begin
            sync_r[0] <= din;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_r[i] <= sync_r[i-1];
            end
            last_r <= samp_s;
            run_r  <= run_s;
        end
    end

    // Run length includes the current sample; it saturates so a stable value is accepted once.
    always_comb begin
        run_s  = RW'(1);
        accept = 1'b0;
        if (same_s) begin
            if (run_r == RUN_MAX) begin
                run_s = RUN_MAX;
            end else begin
                run_s = run_r + RW'(1);
            end
        end else begin
            run_s = RW'(1);
        end
        accept = (run_s == RUN_MAX) && !(same_s && (run_r == RUN_MAX));
    end

    assign value = samp_s;

endmodule

// File: rtl/quadrature_decoder.sv
// 4x quadrature decoder: filtered A/B phases drive a signed wrapping position count,
// a direction flag, a per-step pulse and a sticky illegal-transition flag.
module quadrature_decoder
    import quad_pkg::*;
#(
    parameter int COUNT_WIDTH = 16,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   a_in,
    input  logic                   b_in,
    input  logic                   clr_count,
    input  logic                   clr_err,
    output logic [COUNT_WIDTH-1:0] count,
    output logic                   dir,
    output logic                   step,
    output logic                   err
);

    logic [1:0]             acc_val_s;
    logic                   acc_s;
    cls_e                   cls_s;
    logic                   primed_r, primed_s;
    logic [1:0]             cur_r, cur_s;
    logic [COUNT_WIDTH-1:0] count_r, count_s;
    logic                   dir_r, dir_s;
    logic                   step_r, step_s;
    logic                   err_r, err_s;

    quad_sync_filter #(
        .SYNC_STAGES(SYNC_STAGES),
        .FILTER_LEN (FILTER_LEN)
    ) u_filter (
        .clk   (clk),
        .rst_n (rst_n),
        .din   ({a_in, b_in}),
        .value (acc_val_s),
        .accept(acc_s)
    );

    // Decoder state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            primed_r <= 1'b0;
            cur_r    <= PH_00;
            count_r  <= '0;
            dir_r    <= 1'b0;
            step_r   <= 1'b0;
            err_r    <= 1'b0;
        end else begin
            primed_r <= primed_s;
            cur_r    <= cur_s;
            count_r  <= count_s;
            dir_r    <= dir_s;
            step_r   <= step_s;
            err_r    <= err_s;
        end
    end

    // Classify each accepted phase; the first one after reset only primes cur.
    always_comb begin
        primed_s = primed_r;
        cur_s    = cur_r;
        count_s  = count_r;
        dir_s    = dir_r;
        step_s   = 1'b0;
        err_s    = err_r;
        cls_s    = CLS_NONE;

        if (acc_s) begin
            cur_s    = acc_val_s;
            primed_s = 1'b1;
            if (primed_r) begin
                cls_s = classify(cur_r, acc_val_s);
            end else begin
                cls_s = CLS_NONE;
            end
        end else begin
            cls_s = CLS_NONE;
        end

        case (cls_s)
            CLS_UP: begin
                count_s = count_r + COUNT_WIDTH'(1);
                dir_s   = 1'b1;
                step_s  = 1'b1;
            end
            CLS_DOWN: begin
                count_s = count_r - COUNT_WIDTH'(1);
                dir_s   = 1'b0;
                step_s  = 1'b1;
            end
            default: begin
                count_s = count_r;
                step_s  = 1'b0;
            end
        endcase

        // Clears lose to nothing on count, but a fresh illegal jump beats clr_err.
        if (clr_count) begin
            count_s = '0;
        end else begin
            count_s = count_s;
        end

        if (cls_s == CLS_ILLEGAL) begin
            err_s = 1'b1;
        end else if (clr_err) begin
            err_s = 1'b0;
        end else begin
            err_s = err_r;
        end
    end

    assign count = count_r;
    assign dir   = dir_r;
    assign step  = step_r;
    assign err   = err_r;

endmodule
